// File: rtl/puf_pkg.sv
// puf_pkg: shared challenge width, LFSR taps and sequencer state encoding
package puf_pkg;
  localparam int C_LENGTH = 8;
  localparam logic [C_LENGTH-1:0] LFSR_TAPS = 8'hB8;
  typedef enum logic [2:0] {IDLE, LOAD, RELAX, LAUNCH, DECIDE, DONE} state_t;
endpackage

// File: rtl/puf_lfsr.sv
// puf_lfsr: right-shifting Galois LFSR with seed load; an all-zero seed is forced to 1
module puf_lfsr
  import puf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                step_i,
  input  logic [C_LENGTH-1:0] seed_i,
  output logic [C_LENGTH-1:0] state_o
);
  logic [C_LENGTH-1:0] state_q;
  always_ff @(posedge clk)
    if (!rst_n) state_q <= '0;
    else if (load_i) state_q <= (seed_i == '0) ? C_LENGTH'(1) : seed_i;
    else if (step_i) state_q <= (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : '0);
  assign state_o = state_q;
endmodule

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: drives arbiter-PUF challenges and launch pulses, majority-votes each response bit
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int RESP_BITS  = 8,
  parameter int VOTES      = 7,
  parameter int SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [C_LENGTH-1:0]  i_seed,
  input  logic                 i_puf_resp,
  output logic [C_LENGTH-1:0]  o_challenge,
  output logic                 o_pulse,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [RESP_BITS-1:0] o_response,
  output logic [RESP_BITS-1:0] o_unstable
);
  localparam int VW = $clog2(VOTES + 1);
  localparam int BW = $clog2(RESP_BITS + 1);
  localparam int CW = $clog2(SETTLE_CYC + 2);
  localparam logic [VW-1:0] V_LAST = VW'(VOTES - 1);
  localparam logic [VW-1:0] V_ALL  = VW'(VOTES);
  localparam logic [VW-1:0] V_HALF = VW'(VOTES / 2);
  localparam logic [BW-1:0] B_LAST = BW'(RESP_BITS - 1);
  localparam logic [CW-1:0] RELAX_LAST  = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] LAUNCH_LAST = CW'(SETTLE_CYC + 1);
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [VW-1:0] ones_q, ones_d, vote_q, vote_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [C_LENGTH-1:0] chal_q, chal_d, lfsr;
  logic [RESP_BITS-1:0] resp_q, resp_d, unst_q, unst_d, sel;
  logic pulse_q, busy_q, done_q, lfsr_load, lfsr_step;
  puf_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .seed_i  (i_seed),
    .state_o (lfsr)
  );
  assign sel = RESP_BITS'(1) << bit_q;
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    ones_d    = ones_q;
    vote_d    = vote_q;
    bit_d     = bit_q;
    chal_d    = chal_q;
    resp_d    = resp_q;
    unst_d    = unst_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        lfsr_load = 1'b1;
        bit_d     = '0;
        resp_d    = '0;
        unst_d    = '0;
        state_d   = LOAD;
      end
      LOAD: begin
        chal_d  = lfsr;
        ones_d  = '0;
        vote_d  = '0;
        cyc_d   = '0;
        state_d = RELAX;
      end
      RELAX: begin
        cyc_d   = (cyc_q == RELAX_LAST) ? '0 : cyc_q + CW'(1);
        state_d = (cyc_q == RELAX_LAST) ? LAUNCH : RELAX;
      end
      LAUNCH: if (cyc_q == LAUNCH_LAST) begin
        cyc_d   = '0;
        ones_d  = ones_q + VW'(sync_q[1]);
        vote_d  = vote_q + VW'(1);
        state_d = (vote_q == V_LAST) ? DECIDE : RELAX;
      end else cyc_d = cyc_q + CW'(1);
      DECIDE: begin
        resp_d    = resp_q | ((ones_q > V_HALF) ? sel : '0);
        unst_d    = unst_q | ((ones_q != '0 && ones_q != V_ALL) ? sel : '0);
        lfsr_step = 1'b1;
        bit_d     = bit_q + BW'(1);
        state_d   = (bit_q == B_LAST) ? DONE : LOAD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs register the next state so they line up with the state they describe.
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      cyc_q   <= '0;
      ones_q  <= '0;
      vote_q  <= '0;
      bit_q   <= '0;
      chal_q  <= '0;
      resp_q  <= '0;
      unst_q  <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], i_puf_resp};
      cyc_q   <= cyc_d;
      ones_q  <= ones_d;
      vote_q  <= vote_d;
      bit_q   <= bit_d;
      chal_q  <= chal_d;
      resp_q  <= resp_d;
      unst_q  <= unst_d;
      pulse_q <= state_d == LAUNCH;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
    end
  assign o_challenge = chal_q;
  assign o_pulse     = pulse_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_response  = resp_q;
  assign o_unstable  = unst_q;
endmodule
